mult_hilo_seq: RTL and testbench

//  Multi-cycle 32x32 MIPS multiply unit (mult/multu) owning HI/LO. Splits operands into
//  16-bit halves, drives the combinational 16x16 signed Multiplier one half-pair per

---
 rtl/mult_hilo_seq_pkg.sv | 40 ++++
 rtl/mult_hilo_seq_u16.sv | 34 +++
 rtl/mult_hilo_seq.sv | 153 +++++++++++++++
 tb/tb_mult_hilo_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mult_hilo_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mult_hilo_seq_pkg                                              |
// | Desc   : Shared FSM state encoding, step constants and partial-product  |
// |          shift amounts for the sequential HI/LO multiply unit.          |
// | Rev    : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
package mult_hilo_seq_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Half-pair step order: {A-half, B-half} with 0 = low half, 1 = high half
  localparam logic [1:0] STEP_LL = 2'd0;  // AL*BL
  localparam logic [1:0] STEP_LH = 2'd1;  // AL*BH
  localparam logic [1:0] STEP_HL = 2'd2;  // AH*BL
  localparam logic [1:0] STEP_HH = 2'd3;  // AH*BH

  // Left shift applied to each 32-bit half-pair product before accumulation
  localparam logic [5:0] SHIFT_LO  = 6'd0;
  localparam logic [5:0] SHIFT_MID = 6'd16;
  localparam logic [5:0] SHIFT_HI  = 6'd32;

  // Map a step index onto the weight of its half-pair product
  function automatic logic [5:0] step_shift(input logic [1:0] step);
    logic [5:0] sh;
    case (step)
      STEP_LL: sh = SHIFT_LO;
      STEP_HH: sh = SHIFT_HI;
      default: sh = SHIFT_MID;
    endcase
    return sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_hilo_seq_u16.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mult_hilo_seq_u16                                              |
// | Desc   : Unsigned 16x16 -> 32 product built from a signed 16x16 core.   |
// |          The signed result is corrected by adding back the weight of   |
// |          each operand's top bit: P = S + ((a15?b:0)+(b15?a:0))<<16.    |
// | Rev    : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
module mult_hilo_seq_u16 #(
  parameter int HALF_W = 16
) (
  input  logic [HALF_W-1:0]   i_a,
  input  logic [HALF_W-1:0]   i_b,
  output logic [2*HALF_W-1:0] o_p
);

  logic [2*HALF_W-1:0] w_a_sx;
  logic [2*HALF_W-1:0] w_b_sx;
  logic [2*HALF_W-1:0] w_s;
  logic [2*HALF_W-1:0] w_corr;

  // Signed multiplier core: low 2*HALF_W bits of the sign-extended product
  assign w_a_sx = {{HALF_W{i_a[HALF_W-1]}}, i_a};
  assign w_b_sx = {{HALF_W{i_b[HALF_W-1]}}, i_b};
  assign w_s    = w_a_sx * w_b_sx;

  // Unsigned correction term; anything above bit 2*HALF_W-1 drops out
  assign w_corr = (i_a[HALF_W-1] ? {{HALF_W{1'b0}}, i_b} : '0)
                + (i_b[HALF_W-1] ? {{HALF_W{1'b0}}, i_a} : '0);

  assign o_p = w_s + (w_corr << HALF_W);

endmodule
`default_nettype wire

// File: rtl/mult_hilo_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mult_hilo_seq                                                  |
// | Desc   : Multi-cycle 32x32 mult/multu unit owning HI/LO. One 16x16     |
// |          half-pair per cycle over four cycles, then a sign-fix cycle   |
// |          that writes {HI,LO}. Result visible 5 cycles after start.     |
// |          Optional macro MULT_MADD_EN: madd/maddu accumulate into       |
// |          {HI,LO}; without it the madd input is ignored.                |
// | Rev    : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
module mult_hilo_seq
  import mult_hilo_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic              madd,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int HALF_W = DATA_W / 2;

  state_t              r_state;
  logic [1:0]          r_step;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_neg;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_busy;
  logic                r_done;

  logic [DATA_W-1:0]   w_rs_mag;
  logic [DATA_W-1:0]   w_rt_mag;
  logic [HALF_W-1:0]   w_a_half;
  logic [HALF_W-1:0]   w_b_half;
  logic [DATA_W-1:0]   w_pp;
  logic [2*DATA_W-1:0] w_pp_shifted;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_result;
  logic                w_madd_q;

  // Operand magnitudes; 0x8000_0000 negates to itself and is read as unsigned
  assign w_rs_mag = (is_signed && rs_val[DATA_W-1]) ? (~rs_val + 1'b1) : rs_val;
  assign w_rt_mag = (is_signed && rt_val[DATA_W-1]) ? (~rt_val + 1'b1) : rt_val;

  // Half selection: step bit 1 picks the A half, step bit 0 picks the B half
  assign w_a_half = r_step[1] ? r_a[DATA_W-1:HALF_W] : r_a[HALF_W-1:0];
  assign w_b_half = r_step[0] ? r_b[DATA_W-1:HALF_W] : r_b[HALF_W-1:0];

  mult_hilo_seq_u16 #(
    .HALF_W (HALF_W)
  ) u_u16 (
    .i_a (w_a_half),
    .i_b (w_b_half),
    .o_p (w_pp)
  );

  assign w_pp_shifted = {{DATA_W{1'b0}}, w_pp} << step_shift(r_step);

  // Sign fix of the magnitude product, optionally accumulated onto {HI,LO}
  assign w_prod   = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_result = w_prod + (w_madd_q ? {r_hi, r_lo} : '0);

`ifdef MULT_MADD_EN
  logic r_madd;
  assign w_madd_q = r_madd;

  // madd request captured with the operands at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_madd <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_madd <= madd;
    end
  end
`else
  logic w_unused_madd;
  assign w_unused_madd = madd;
  assign w_madd_q      = 1'b0;
`endif

  // Controller: operand capture, four accumulate steps, sign fix and HI/LO writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_LL;
      r_a     <= '0;
      r_b     <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // start has priority; a same-edge mthi/mtlo is dropped
            r_a     <= w_rs_mag;
            r_b     <= w_rt_mag;
            r_neg   <= is_signed & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
            r_acc   <= '0;
            r_step  <= STEP_LL;
            r_busy  <= 1'b1;
            r_state <= ST_MUL;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        ST_MUL: begin
          r_acc  <= r_acc + w_pp_shifted;
          r_step <= r_step + 2'd1;
          if (r_step == STEP_HH) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          {r_hi, r_lo} <= w_result;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_mult_hilo_seq                                               |
// | Desc   : Directed self-checking bench for mult_hilo_seq with            |
// |          hand-computed HI/LO results. Exercises MULT_MADD_EN when set. |
// | Rev    : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
module tb_mult_hilo_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic        madd;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_bad;

  mult_hilo_seq #(
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .madd      (madd),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then wait for done and check it lands on the 5th edge
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic md);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1; is_signed = sgn; rs_val = a; rt_val = b; madd = md;
    @(posedge clk); #1;
    start = 1'b0; madd = 1'b0; rs_val = 32'h0; rt_val = 32'h0; is_signed = 1'b0;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (done) lat = c;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd5);
  endtask

  // mthi / mtlo in idle
  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b0; wdata = h;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = l;
    @(negedge clk);
    lo_we = 1'b0; wdata = 32'h0;
  endtask

  initial begin
    int ndone;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; madd = 1'b0;
    rs_val = 32'h0; rt_val = 32'h0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Signed -1 * 2
    run_op("s_m1x2", 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    chk("s_m1x2_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("s_m1x2_idle", {62'd0, busy, done}, 64'd1);
    @(posedge clk); #1;
    chk("s_m1x2_pulse", {63'd0, done}, 64'd0);

    // Unsigned max * max
    run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("u_max_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Signed most-negative squared
    run_op("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("s_min2_res", {hi, lo}, 64'h4000_0000_0000_0000);

    // Signed most-positive squared
    run_op("s_max2", 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    chk("s_max2_res", {hi, lo}, 64'h3FFF_FFFF_0000_0001);

    // Unsigned low halves with bit 15 set, and a cross-half product
    run_op("u_ffff", 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
    chk("u_ffff_res", {hi, lo}, 64'h0000_0000_FFFE_0001);
    run_op("s_m1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("s_m1m1_res", {hi, lo}, 64'h0000_0000_0000_0001);

    // Second start at E2 is ignored; only one done pulse
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000;
    @(posedge clk); #1;
    start = 1'b0; rs_val = 32'h0; rt_val = 32'h0;
    @(posedge clk); #1;
    start = 1'b1; rs_val = 32'd7; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; rs_val = 32'h0; rt_val = 32'h0;
    ndone = 0;
    for (int c = 3; c <= 14; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("restart_ndone", 64'(ndone), 64'd1);
    chk("restart_res", {hi, lo}, 64'h0000_0001_0000_0000);

    // Asynchronous reset in the middle of MUL
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; rs_val = 32'h0000_FFFF; rt_val = 32'h0000_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("s_3xm4", 1'b1, 32'd3, 32'hFFFF_FFFC, 1'b0);
    chk("s_3xm4_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);

    // Idle mthi / mtlo
    write_hilo(32'h0000_1234, 32'h0000_5678);
    chk("mthilo", {hi, lo}, 64'h0000_1234_0000_5678);

    // Same-edge start and write: write dropped; writes while busy ignored
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; rs_val = 32'd2; rt_val = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_DEAD;
    @(posedge clk); #1;
    start = 1'b0;
    chk("wr_drop", {hi, lo}, 64'h0000_1234_0000_5678);
    @(posedge clk); #1;
    chk("wr_busy", {hi, lo}, 64'h0000_1234_0000_5678);
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
    ndone = 0;
    for (int c = 2; c <= 10 && ndone == 0; c++) begin
      @(posedge clk); #1;
      if (done) ndone = c;
    end
    chk("wr_lat", 64'(ndone), 64'd5);
    chk("wr_res", {hi, lo}, 64'h0000_0000_0000_0006);

    // madd onto {HI,LO} = 0:5
    write_hilo(32'h0, 32'h5);
`ifdef MULT_MADD_EN
    run_op("madd_3x4", 1'b1, 32'd3, 32'd4, 1'b1);
    chk("madd_3x4_res", {hi, lo}, 64'h0000_0000_0000_0011);
    run_op("madd_m1x1", 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("madd_m1x1_res", {hi, lo}, 64'h0000_0000_0000_0010);
`else
    run_op("madd_off", 1'b1, 32'd3, 32'd4, 1'b1);
    chk("madd_off_res", {hi, lo}, 64'h0000_0000_0000_000C);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
